// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/WAIT/ISSUE sequencer with PC and next-PC selection.
// Optional alignment trap enabled by defining FETCH_ALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic        instrValid,
  input  logic        instrDone,
  input  logic [1:0]  pcSrcCtrl,
  input  logic [25:0] jAddr,
  input  logic [31:0] imm,
  input  logic [31:0] jrTarget,
  input  logic        aluZero,
  input  logic        bneCtrl,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
`ifdef FETCH_ALIGN_TRAP_EN
  , output logic      trap
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        started_q, started_d;
  logic        trap_q, trap_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc_raw;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc_raw = pc_plus4;
    case (pcSrcCtrl)
      2'd1:    next_pc_raw = {pc_plus4[31:28], jAddr, 2'b00};
      2'd2:    next_pc_raw = jrTarget;
      2'd3:    next_pc_raw = (aluZero ^ bneCtrl) ? (pc_plus4 + (imm << 2)) : pc_plus4;
      default: next_pc_raw = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      started_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      started_q <= started_d;
      trap_q    <= trap_d;
    end
  end

  // started_q holds the request off for the first cycle after reset release
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    started_d = 1'b1;
    trap_d    = trap_q;
    case (state_q)
      S_FETCH, S_WAIT: begin
        if (started_q) begin
          if (imemAck) begin
            instr_d = imemRdata;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_ISSUE: begin
        if (instrDone && !trap_q) begin
          valid_d = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
          if (|next_pc_raw[1:0]) begin
            trap_d = 1'b1;
          end else begin
            pc_d    = next_pc_raw;
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc_raw & ~32'd3;
          state_d = S_FETCH;
`endif
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imemReq = 1'b0;
    if (started_q && (state_q == S_FETCH || state_q == S_WAIT)) begin
      imemReq = 1'b1;
    end
  end

  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign instrValid = valid_q;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
`ifdef FETCH_ALIGN_TRAP_EN
  assign trap       = trap_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, multi-cycle sequences, random vs model.
module tb_fetch_unit;
  localparam logic [31:0] RP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrDone;
  logic [1:0]  pcSrcCtrl;
  logic [25:0] jAddr;
  logic [31:0] imm;
  logic [31:0] jrTarget;
  logic        aluZero;
  logic        bneCtrl;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
`ifdef FETCH_ALIGN_TRAP_EN
  logic        trap;
`endif

  int n_run = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(RP)) dut (
    .clk(clk), .rstN(rstN), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemRdata(imemRdata), .instr(instr), .instrValid(instrValid),
    .instrDone(instrDone), .pcSrcCtrl(pcSrcCtrl), .jAddr(jAddr), .imm(imm),
    .jrTarget(jrTarget), .aluZero(aluZero), .bneCtrl(bneCtrl), .pc(pc), .pcPlus4(pcPlus4)
`ifdef FETCH_ALIGN_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic [1:0]  src;
    logic [25:0] ja;
    logic [31:0] im;
    logic [31:0] jr;
    logic        z;
    logic        b;
    logic [31:0] exp_pc;
    logic        exp_trap;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, applied to the aligned result when no trap logic exists
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] src,
                                           input logic [25:0] ja, input logic [31:0] im,
                                           input logic [31:0] jr, input logic z, input logic b);
    logic [31:0] p4;
    logic [31:0] r;
    p4 = p + 32'd4;
    case (src)
      2'd0: r = p4;
      2'd1: r = {p4[31:28], ja, 2'b00};
      2'd2: r = jr;
      default: r = ((z ^ b) == 1'b1) ? p4 + im * 32'd4 : p4;
    endcase
`ifndef FETCH_ALIGN_TRAP_EN
    r = {r[31:2], 2'b00};
`endif
    return r;
  endfunction

  task automatic do_reset();
    rstN = 1'b0;
    imemAck = 1'b0;
    instrDone = 1'b0;
    #2;
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_valid", {31'd0, instrValid}, 32'd0);
    chk("rst_pc", pc, RP);
    chk("rst_instr", instr, 32'd0);
`ifdef FETCH_ALIGN_TRAP_EN
    chk("rst_trap", {31'd0, trap}, 32'd0);
`endif
    tick();
    rstN = 1'b1;
    tick();
    chk("post_rst_req", {31'd0, imemReq}, 32'd1);
    chk("post_rst_addr", imemAddr, RP);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imemReq && k < 20) begin
      tick();
      k++;
    end
    chk("req_timeout", {31'd0, imemReq}, 32'd1);
  endtask

  task automatic deliver(input logic [31:0] d);
    wait_req();
    imemAck = 1'b1;
    imemRdata = d;
    tick();
    imemAck = 1'b0;
    chk("deliver_valid", {31'd0, instrValid}, 32'd1);
    chk("deliver_instr", instr, d);
  endtask

  task automatic retire(input logic [1:0] src, input logic [25:0] ja, input logic [31:0] im,
                        input logic [31:0] jr, input logic z, input logic b);
    chk("retire_valid", {31'd0, instrValid}, 32'd1);
    pcSrcCtrl = src; jAddr = ja; imm = im; jrTarget = jr; aluZero = z; bneCtrl = b;
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    pcSrcCtrl = 2'd0;
  endtask

  task automatic goto_pc(input logic [31:0] p);
    deliver(32'hDEAD_0000);
    retire(2'd2, 26'd0, 32'd0, p, 1'b0, 1'b0);
    chk("goto_pc", pc, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        r_ack, r_done, r_z, r_b;
    logic [31:0] r_dat, r_im, r_jr;
    logic [1:0]  r_src;
    logic [25:0] r_ja;

    tbl[0] = '{32'h0040_0010, 2'd1, 26'h0000100, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0400, 1'b0};
    tbl[1] = '{32'h0000_0100, 2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, 32'h0000_00FC, 1'b0};
    tbl[2] = '{32'h0000_0100, 2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b1, 32'h0000_0104, 1'b0};
    tbl[3] = '{32'h0000_0100, 2'd3, 26'd0, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 32'h0000_0104, 1'b0};
    tbl[4] = '{32'h0000_0200, 2'd3, 26'd0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'h0000_0244, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    tbl[6] = '{32'hF000_0000, 2'd1, 26'h3FF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0};
`ifdef FETCH_ALIGN_TRAP_EN
    tbl[7] = '{32'hFFFF_FFFC, 2'd2, 26'd0, 32'd0, 32'h0000_0102, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1};
`else
    tbl[7] = '{32'hFFFF_FFFC, 2'd2, 26'd0, 32'd0, 32'h0000_0102, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
`endif

    rstN = 1'b1;
    imemAck = 1'b0; imemRdata = 32'd0; instrDone = 1'b0;
    pcSrcCtrl = 2'd0; jAddr = 26'd0; imm = 32'd0; jrTarget = 32'd0;
    aluZero = 1'b0; bneCtrl = 1'b0;
    #7;
    do_reset();

    // Zero-wait memory: ack in the FETCH cycle, retire immediately with INC4
    for (int i = 0; i < 3; i++) begin
      chk("zw_req", {31'd0, imemReq}, 32'd1);
      chk("zw_addr", imemAddr, 32'(i * 4));
      imemAck = 1'b1;
      imemRdata = 32'hA000_0000 + 32'(i);
      tick();
      imemAck = 1'b0;
      chk("zw_valid", {31'd0, instrValid}, 32'd1);
      chk("zw_req_off", {31'd0, imemReq}, 32'd0);
      retire(2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("zw_valid_drop", {31'd0, instrValid}, 32'd0);
    end

    // Slow memory: ack after 5 cycles
    wait_req();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("slow_req", {31'd0, imemReq}, 32'd1);
      chk("slow_valid", {31'd0, instrValid}, 32'd0);
    end
    imemAck = 1'b1;
    imemRdata = 32'h1234_5678;
    tick();
    imemAck = 1'b0;
    chk("slow_instr", instr, 32'h1234_5678);
    chk("slow_valid_on", {31'd0, instrValid}, 32'd1);
    // Stray ack and held instr while in ISSUE
    imemAck = 1'b1;
    imemRdata = 32'hBAD0_BAD0;
    tick();
    imemAck = 1'b0;
    chk("issue_hold_instr", instr, 32'h1234_5678);
    chk("issue_hold_pc", pc, 32'h0000_000C);
    retire(2'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Stray instrDone while waiting for memory
    instrDone = 1'b1;
    pcSrcCtrl = 2'd2;
    jrTarget = 32'h0000_8000;
    tick();
    instrDone = 1'b0;
    pcSrcCtrl = 2'd0;
    chk("done_ignored_pc", pc, 32'h0000_0010);

    for (int i = 0; i < 8; i++) begin
      goto_pc(tbl[i].start);
      chk("vec_pc_plus4", pcPlus4, tbl[i].start + 32'd4);
      deliver(32'h0BAD_F00D);
      retire(tbl[i].src, tbl[i].ja, tbl[i].im, tbl[i].jr, tbl[i].z, tbl[i].b);
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
`ifdef FETCH_ALIGN_TRAP_EN
      chk($sformatf("vec%0d_trap", i), {31'd0, trap}, {31'd0, tbl[i].exp_trap});
`endif
      if (tbl[i].exp_trap) begin
        tick();
        chk("trap_valid", {31'd0, instrValid}, 32'd0);
        chk("trap_req", {31'd0, imemReq}, 32'd0);
      end else begin
        wait_req();
        chk($sformatf("vec%0d_addr", i), imemAddr, tbl[i].exp_pc);
      end
    end

    // Reset while a request is outstanding
    do_reset();
    goto_pc(32'h0000_0500);
    wait_req();
    tick();
    chk("midwait_req", {31'd0, imemReq}, 32'd1);
    do_reset();

    // Random run against a transaction-level model
    m_pc = RP;
    m_valid = 1'b0;
    m_instr = 32'd0;
    for (int c = 0; c < 500; c++) begin
      chk("rnd_req", {31'd0, imemReq}, {31'd0, !m_valid});
      chk("rnd_valid", {31'd0, instrValid}, {31'd0, m_valid});
      chk("rnd_pc", pc, m_pc);
      chk("rnd_pc4", pcPlus4, m_pc + 32'd4);
      if (!m_valid) chk("rnd_addr", imemAddr, m_pc);
      if (m_valid) chk("rnd_instr", instr, m_instr);
      r_ack = ($urandom_range(0, 2) == 0);
      r_done = $urandom_range(0, 1) == 1;
      r_dat = $urandom;
      r_src = 2'($urandom_range(0, 3));
      r_ja = 26'($urandom);
      r_im = 32'($signed(16'($urandom)));
      r_jr = $urandom;
`ifdef FETCH_ALIGN_TRAP_EN
      r_jr[1:0] = 2'b00;
`endif
      r_z = 1'($urandom);
      r_b = 1'($urandom);
      imemAck = r_ack; imemRdata = r_dat; instrDone = r_done;
      pcSrcCtrl = r_src; jAddr = r_ja; imm = r_im; jrTarget = r_jr;
      aluZero = r_z; bneCtrl = r_b;
      if (!m_valid && r_ack) begin
        m_valid = 1'b1;
        m_instr = r_dat;
      end else if (m_valid && r_done) begin
        m_pc = ref_next(m_pc, r_src, r_ja, r_im, r_jr, r_z, r_b);
        m_valid = 1'b0;
      end
      tick();
    end
    imemAck = 1'b0;
    instrDone = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
